// File: rtl/ikaopll_pkg.sv
// Shared constants, frame-state encoding and sign-extension helpers for the OPLL output path.
package ikaopll_pkg;

  localparam int unsigned OP_W      = 9;
  localparam int unsigned ACC_W     = 13;
  localparam int unsigned MIX_W     = 16;
  localparam int unsigned FRAME_LEN = 18;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} frame_state_e;

  function automatic logic [ACC_W-1:0] sext_op(input logic [OP_W-1:0] op);
    return {{(ACC_W-OP_W){op[OP_W-1]}}, op};
  endfunction

  function automatic logic [MIX_W-1:0] sext_acc(input logic [ACC_W-1:0] acc);
    return {{(MIX_W-ACC_W){acc[ACC_W-1]}}, acc};
  endfunction

endpackage

// File: rtl/ikaopll_frame_checker.sv
// Tracks phi1 ticks between cycle-00 markers, sequences IDLE/ARMED/RUN and flags bad frame lengths.
module ikaopll_frame_checker
  import ikaopll_pkg::*;
(
  input  logic i_EMUCLK,
  input  logic i_IC_n,
  input  logic i_phi1_NCEN_n,
  input  logic i_CYCLE_00,
  output logic close_c,
  output logic smpl_ok_c,
  output logic frame_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(31);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_LEN - 1);

  frame_state_e     state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_c;
  logic             len_ok_c;

  assign tick_c    = ~i_phi1_NCEN_n;
  assign close_c   = tick_c & i_CYCLE_00;
  assign len_ok_c  = (tick_cnt == CNT_GOOD);
  assign smpl_ok_c = close_c & (state != IDLE) & len_ok_c;

  // The first close after reset only aligns to the frame; later closes are length-checked.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      frame_err <= 1'b0;
    end else if (tick_c) begin
      if (i_CYCLE_00) begin
        tick_cnt <= '0;
        case (state)
          IDLE: state <= ARMED;
          default: begin
            if (len_ok_c) begin
              state <= RUN;
            end else begin
              state     <= ARMED;
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (tick_cnt != CNT_MAX) begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ikaopll_output_accumulator.sv
// Per-frame melody/rhythm accumulation and mixed sample output for the OPLL emulator audio path.
// IKAOPLL_RHYTHM_BOOST_EN: when defined, rhythm is weighted x2 in o_MIX (o_MO/o_RO unaffected).
module ikaopll_output_accumulator
  import ikaopll_pkg::*;
(
  input  logic                    i_EMUCLK,
  input  logic                    i_IC_n,
  input  logic                    i_phi1_NCEN_n,
  input  logic                    i_CYCLE_00,
  input  logic                    i_MO_CTRL,
  input  logic                    i_RO_CTRL,
  input  logic signed [OP_W-1:0]  i_OP_OUT,
  output logic signed [ACC_W-1:0] o_MO,
  output logic signed [ACC_W-1:0] o_RO,
  output logic signed [MIX_W-1:0] o_MIX,
  output logic                    o_SMPL_VALID,
  output logic                    o_FRAME_ERR
);

  logic             tick_c;
  logic             close_c;
  logic             smpl_ok_c;
  logic [ACC_W-1:0] acc_m;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] add_m_c;
  logic [ACC_W-1:0] add_r_c;
  logic [ACC_W-1:0] sum_m_c;
  logic [ACC_W-1:0] sum_r_c;
  logic [MIX_W-1:0] rhy_c;
  logic [MIX_W-1:0] mix_c;

  ikaopll_frame_checker u_frame_checker (
    .i_EMUCLK      (i_EMUCLK),
    .i_IC_n        (i_IC_n),
    .i_phi1_NCEN_n (i_phi1_NCEN_n),
    .i_CYCLE_00    (i_CYCLE_00),
    .close_c       (close_c),
    .smpl_ok_c     (smpl_ok_c),
    .frame_err     (o_FRAME_ERR)
  );

  assign tick_c  = ~i_phi1_NCEN_n;
  assign add_m_c = i_MO_CTRL ? sext_op(i_OP_OUT) : '0;
  assign add_r_c = i_RO_CTRL ? sext_op(i_OP_OUT) : '0;
  assign sum_m_c = acc_m + add_m_c;
  assign sum_r_c = acc_r + add_r_c;

`ifdef IKAOPLL_RHYTHM_BOOST_EN
  assign rhy_c = sext_acc(sum_r_c) << 1;
`else
  assign rhy_c = sext_acc(sum_r_c);
`endif

  assign mix_c = sext_acc(sum_m_c) + rhy_c;

  // Closing slot's own contribution belongs to the frame being closed.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      acc_m        <= '0;
      acc_r        <= '0;
      o_MO         <= '0;
      o_RO         <= '0;
      o_MIX        <= '0;
      o_SMPL_VALID <= 1'b0;
    end else if (tick_c) begin
      o_SMPL_VALID <= smpl_ok_c;
      if (close_c) begin
        o_MO  <= sum_m_c;
        o_RO  <= sum_r_c;
        o_MIX <= mix_c;
        acc_m <= '0;
        acc_r <= '0;
      end else begin
        acc_m <= sum_m_c;
        acc_r <= sum_r_c;
      end
    end
  end

endmodule
